// File: rtl/relm_mul_server.sv
// relm_mul_server: iterative unsigned multiplier serving ReLM custom-op requests.
// Radix-4 shift-add loop: two multiplier bits are consumed per RUN cycle, and the
// loop stops as soon as the remaining multiplier bits are all zero.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   mul_req_in      - request strobe; mul_a_in/mul_x_in are valid while high
//   mul_a_in        - multiplicand (WD bits, unsigned)
//   mul_x_in        - multiplier (WD bits, unsigned)
//   mul_ax_out      - registered 2*WD-bit product
//   mul_valid_out   - high while mul_ax_out holds the latest accepted request's product
//   busy_out        - high while a multiplication is in progress
//   retry_out       - combinational; request refused because the unit is busy
module relm_mul_server #(
    parameter int unsigned WD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_req_in,
    input  logic [WD-1:0]   mul_a_in,
    input  logic [WD-1:0]   mul_x_in,
    output logic [2*WD-1:0] mul_ax_out,
    output logic            mul_valid_out,
    output logic            busy_out,
    output logic            retry_out
);

    localparam int unsigned PW = 2 * WD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ar;
    logic [PW-1:0]   acc;
    logic [WD-1:0]   xr;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_nxt;
    logic [WD-1:0]   xr_nxt;

    // Radix-4 partial product: ar * xr[1:0] built from ar and ar<<1.
    always_comb begin
        pp = '0;
        if (xr[0]) pp = ar;
        if (xr[1]) pp = pp + (ar << 1);
        acc_nxt = acc + pp;
        xr_nxt  = xr >> 2;
    end

    assign retry_out = mul_req_in & busy_out;

    // Control and datapath; IDLE and DONE both accept, DONE additionally holds the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ar            <= '0;
            acc           <= '0;
            xr            <= '0;
            mul_ax_out    <= '0;
            mul_valid_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (mul_req_in) begin
                        ar            <= PW'(mul_a_in);
                        xr            <= mul_x_in;
                        acc           <= '0;
                        mul_valid_out <= 1'b0;
                        busy_out      <= 1'b1;
                        state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    ar  <= ar << 2;
                    xr  <= xr_nxt;
                    // Early exit once no multiplier bits remain.
                    if (xr_nxt == '0) begin
                        mul_ax_out    <= acc_nxt;
                        mul_valid_out <= 1'b1;
                        busy_out      <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relm_mul_server.sv
// Bench for relm_mul_server: behavioural model (product via plain multiply, run length
// from the multiplier's MSB position) compared every cycle, plus directed literal checks.
module tb_relm_mul_server;

    localparam int unsigned WD = 32;
    localparam int unsigned PW = 2 * WD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mul_req_in = 1'b0;
    logic [WD-1:0] mul_a_in = '0;
    logic [WD-1:0] mul_x_in = '0;
    logic [PW-1:0] mul_ax_out;
    logic          mul_valid_out;
    logic          busy_out;
    logic          retry_out;

    int compared   = 0;
    int mismatched = 0;

    relm_mul_server #(.WD(WD)) dut (
        .clk           (clk),
        .rst           (rst),
        .mul_req_in    (mul_req_in),
        .mul_a_in      (mul_a_in),
        .mul_x_in      (mul_x_in),
        .mul_ax_out    (mul_ax_out),
        .mul_valid_out (mul_valid_out),
        .busy_out      (busy_out),
        .retry_out     (retry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of cycles needed: one per 2-bit multiplier digit up to the MSB, at least one.
    function automatic int nrun(input logic [WD-1:0] x);
        int msb = -1;
        for (int i = 0; i < int'(WD); i++) if (x[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2) / 2;
    endfunction

    // Behavioural model: pending product plus remaining-cycle counter.
    int            m_left  = 0;
    logic [PW-1:0] m_pend  = '0;
    logic [PW-1:0] m_ax    = '0;
    logic          m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_ax    <= '0;
            m_valid <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ax    <= m_pend;
                m_valid <= 1'b1;
            end
        end else if (mul_req_in) begin
            m_pend  <= PW'(mul_a_in) * PW'(mul_x_in);
            m_left  <= nrun(mul_x_in);
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",  PW'(busy_out),      PW'(m_left > 0));
            chk("retry", PW'(retry_out),     PW'(mul_req_in && (m_left > 0)));
            chk("valid", PW'(mul_valid_out), PW'(m_valid));
            chk("ax",    mul_ax_out,         m_ax);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE/DONE, wait for valid; returns latency and busy cycles.
    task automatic do_req(input logic [WD-1:0] a, input logic [WD-1:0] x,
                          output int lat, output int bcnt);
        mul_req_in = 1'b1;
        mul_a_in   = a;
        mul_x_in   = x;
        step();
        mul_req_in = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (mul_valid_out) break;
            if (busy_out) bcnt++;
            lat++;
            step();
        end
        if (!mul_valid_out) chk("valid_timeout", PW'(mul_valid_out), PW'(1));
    endtask

    int lat, bcnt, rcnt;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        step();
        step();
        chk("rst_ax",    mul_ax_out,         '0);
        chk("rst_valid", PW'(mul_valid_out), '0);
        chk("rst_busy",  PW'(busy_out),      '0);
        rst = 1'b0;
        step();
        chk("idle_retry", PW'(retry_out), '0);

        // 7*6 from IDLE.
        do_req(32'd7, 32'd6, lat, bcnt);
        chk("t1_lat",  PW'(lat),  PW'(2));
        chk("t1_busy", PW'(bcnt), PW'(2));
        chk("t1_ax",   mul_ax_out, PW'(42));
        chk("t1_model", m_ax, PW'(42));

        // Max-length operation.
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("t2_lat", PW'(lat), PW'(16));
        chk("t2_ax",  mul_ax_out, 64'hFFFF_FFFE_0000_0001);
        chk("t2_model", m_ax, 64'hFFFF_FFFE_0000_0001);

        // Back-to-back from DONE: x=0 then x=3.
        mul_req_in = 1'b1; mul_a_in = 32'h1234_5678; mul_x_in = 32'd0;
        step();
        mul_a_in = 32'hFFFF_FFFF; mul_x_in = 32'd3;
        chk("t3_busy0", PW'(busy_out), PW'(1));
        step();
        chk("t3_valid1", PW'(mul_valid_out), PW'(1));
        chk("t3_ax1",    mul_ax_out, '0);
        chk("t3_retry",  PW'(retry_out), '0);
        step();
        mul_req_in = 1'b0;
        chk("t3_gap", PW'(mul_valid_out), '0);
        step();
        chk("t3_valid2", PW'(mul_valid_out), PW'(1));
        chk("t3_ax2",    mul_ax_out, 64'h2_FFFF_FFFD);

        // Request held during RUN is refused, then accepted on the first DONE cycle.
        mul_req_in = 1'b1; mul_a_in = 32'd5; mul_x_in = 32'h8000_0000;
        step();
        mul_a_in = 32'd9; mul_x_in = 32'd9;
        bcnt = 0; rcnt = 0;
        for (int i = 0; i < 40 && !mul_valid_out; i++) begin
            if (busy_out) bcnt++;
            if (retry_out) rcnt++;
            step();
        end
        chk("t4_busy",  PW'(bcnt), PW'(16));
        chk("t4_retry", PW'(rcnt), PW'(16));
        chk("t4_ax",    mul_ax_out, 64'h2_8000_0000);
        chk("t4_done_retry", PW'(retry_out), '0);
        step();
        mul_req_in = 1'b0;
        chk("t4_acc_valid", PW'(mul_valid_out), '0);
        step();
        step();
        chk("t4_ax2", mul_ax_out, PW'(81));

        // Asynchronous reset during RUN cycle 3.
        mul_req_in = 1'b1; mul_a_in = 32'hFFFF_FFFF; mul_x_in = 32'hFFFF_FFFF;
        step();
        mul_req_in = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_ax",    mul_ax_out,         '0);
        chk("t5_rst_valid", PW'(mul_valid_out), '0);
        chk("t5_rst_busy",  PW'(busy_out),      '0);
        step();
        rst = 1'b0;
        do_req(32'd2, 32'd3, lat, bcnt);
        chk("t5_lat", PW'(lat), PW'(1));
        chk("t5_ax",  mul_ax_out, PW'(6));

        // Randomised traffic; the per-cycle compare process checks everything.
        for (int c = 0; c < 3000; c++) begin
            mul_req_in = ($urandom_range(0, 2) != 0);
            mul_a_in   = $urandom;
            mul_x_in   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) mul_x_in = WD'($urandom_range(0, 3));
            step();
        end
        mul_req_in = 1'b0;
        for (int c = 0; c < 20; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
